// File: rtl/blob_mover.sv
// Per-frame sprite motion controller: on each vsync falling edge the sprite corner
// steps by `speed` pixels per axis, and it reflects off the screen limits.
module blob_mover #(
    parameter int WIDTH    = 16,
    parameter int HEIGHT   = 16,
    parameter int SCREEN_W = 1024,
    parameter int SCREEN_H = 768,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        launch,
    input  logic        stop,
    input  logic        pause,
    input  logic [2:0]  speed,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        moving,
    output logic        bounce
);

    localparam logic [11:0] X_MAX  = 12'(SCREEN_W - WIDTH);
    localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - HEIGHT);
    localparam logic [10:0] X_PARK = 11'(X_INIT);
    localparam logic [9:0]  Y_PARK = 10'(Y_INIT);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, STEP_X, STEP_Y} state_t;

    state_t      state_reg, state_next;
    logic [10:0] x_reg, x_next;
    logic [9:0]  y_reg, y_next;
    logic        dx_neg_reg, dx_neg_next;
    logic        dy_neg_reg, dy_neg_next;
    logic [2:0]  spd_reg, spd_next;
    logic        vsync_d_reg;
    logic        bounce_reg, bounce_next;

    logic        tick;
    logic [11:0] spd_ext, x_ext, y_ext;
    logic [11:0] x_sum, x_diff, y_sum, y_diff;

    assign tick    = vsync_d_reg & ~vsync;
    assign spd_ext = {9'd0, spd_reg};
    assign x_ext   = {1'b0, x_reg};
    assign y_ext   = {2'b00, y_reg};
    assign x_sum   = x_ext + spd_ext;
    assign x_diff  = x_ext - spd_ext;
    assign y_sum   = y_ext + spd_ext;
    assign y_diff  = y_ext - spd_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            x_reg       <= X_PARK;
            y_reg       <= Y_PARK;
            dx_neg_reg  <= 1'b0;
            dy_neg_reg  <= 1'b0;
            spd_reg     <= 3'd0;
            vsync_d_reg <= 1'b1;
            bounce_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            dx_neg_reg  <= dx_neg_next;
            dy_neg_reg  <= dy_neg_next;
            spd_reg     <= spd_next;
            vsync_d_reg <= vsync;
            bounce_reg  <= bounce_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        dx_neg_next = dx_neg_reg;
        dy_neg_next = dy_neg_reg;
        spd_next    = spd_reg;
        bounce_next = 1'b0;

        if (stop) begin
            // stop overrides any pending tick, launch or step
            state_next  = IDLE;
            x_next      = X_PARK;
            y_next      = Y_PARK;
            dx_neg_next = 1'b0;
            dy_neg_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (launch) state_next = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (tick && !pause) begin
                        spd_next   = speed;
                        state_next = STEP_X;
                    end
                end
                STEP_X: begin
                    state_next = STEP_Y;
                    if (!dx_neg_reg) begin
                        if (x_sum > X_MAX) begin
                            x_next      = X_MAX[10:0];
                            dx_neg_next = 1'b1;
                            bounce_next = 1'b1;
                        end else begin
                            x_next = x_sum[10:0];
                        end
                    end else if (x_ext < spd_ext) begin
                        x_next      = 11'd0;
                        dx_neg_next = 1'b0;
                        bounce_next = 1'b1;
                    end else begin
                        x_next = x_diff[10:0];
                    end
                end
                STEP_Y: begin
                    state_next = WAIT_FRAME;
                    if (!dy_neg_reg) begin
                        if (y_sum > Y_MAX) begin
                            y_next      = Y_MAX[9:0];
                            dy_neg_next = 1'b1;
                            bounce_next = 1'b1;
                        end else begin
                            y_next = y_sum[9:0];
                        end
                    end else if (y_ext < spd_ext) begin
                        y_next      = 10'd0;
                        dy_neg_next = 1'b0;
                        bounce_next = 1'b1;
                    end else begin
                        y_next = y_diff[9:0];
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign x      = x_reg;
    assign y      = y_reg;
    assign moving = (state_reg != IDLE);
    assign bounce = bounce_reg;

endmodule

// File: tb/tb_blob_mover.sv
// Bench for blob_mover: three instances with different park positions share stimulus;
// expected per-frame positions are queued when a tick is driven and checked as they appear.
module tb_blob_mover;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vsync = 1'b1;
    logic        launch = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [2:0]  speed = 3'd0;

    logic [2:0][10:0] xs;
    logic [2:0][9:0]  ys;
    logic [2:0]       ms;
    logic [2:0]       bs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
        bit bx;
        bit by;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    blob_mover u0 (
        .clk(clk), .reset(reset), .vsync(vsync), .launch(launch), .stop(stop),
        .pause(pause), .speed(speed), .x(xs[0]), .y(ys[0]), .moving(ms[0]), .bounce(bs[0])
    );
    blob_mover #(.X_INIT(1004), .Y_INIT(100)) u1 (
        .clk(clk), .reset(reset), .vsync(vsync), .launch(launch), .stop(stop),
        .pause(pause), .speed(speed), .x(xs[1]), .y(ys[1]), .moving(ms[1]), .bounce(bs[1])
    );
    blob_mover #(.X_INIT(1008), .Y_INIT(752)) u2 (
        .clk(clk), .reset(reset), .vsync(vsync), .launch(launch), .stop(stop),
        .pause(pause), .speed(speed), .x(xs[2]), .y(ys[2]), .moving(ms[2]), .bounce(bs[2])
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        launch = 1'b0; stop = 1'b0; pause = 1'b0; vsync = 1'b1; speed = 3'd0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic do_launch();
        launch = 1'b1;
        cyc();
        launch = 1'b0;
        checks++;
        if (ms !== 3'b111) begin
            errors++;
            $display("FAIL launch_moving: got %b want 111", ms);
        end
    endtask

    // One frame: drive a tick, then check x at T+2 and y at T+3 against the queued entry.
    task automatic do_frame(input int inst, input logic [2:0] spd, input int ex, input int ey,
                            input bit ebx, input bit eby, input int chg);
        exp_t e;
        int y0;
        sb_q.push_back('{x: ex, y: ey, bx: ebx, by: eby});
        y0 = int'(ys[inst]);
        speed = spd;
        vsync = 1'b0;
        cyc();
        checks++;
        if (ms[inst] !== 1'b1) begin
            errors++;
            $display("FAIL frame_moving[%0d]: got %b want 1", inst, ms[inst]);
        end
        if (chg >= 0) speed = chg[2:0];
        cyc();
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries want 1", inst);
            e = '{x: -1, y: -1, bx: 1'b0, by: 1'b0};
        end else begin
            e = sb_q.pop_front();
        end
        checks += 3;
        if (int'(xs[inst]) != e.x) begin
            errors++;
            $display("FAIL frame_x[%0d]: got %0d want %0d", inst, xs[inst], e.x);
        end
        if (bs[inst] !== e.bx) begin
            errors++;
            $display("FAIL frame_bounce_x[%0d]: got %b want %b", inst, bs[inst], e.bx);
        end
        if (int'(ys[inst]) != y0) begin
            errors++;
            $display("FAIL frame_y_early[%0d]: got %0d want %0d", inst, ys[inst], y0);
        end
        cyc();
        checks += 3;
        if (int'(ys[inst]) != e.y) begin
            errors++;
            $display("FAIL frame_y[%0d]: got %0d want %0d", inst, ys[inst], e.y);
        end
        if (bs[inst] !== e.by) begin
            errors++;
            $display("FAIL frame_bounce_y[%0d]: got %b want %b", inst, bs[inst], e.by);
        end
        if (int'(xs[inst]) != e.x) begin
            errors++;
            $display("FAIL frame_x_hold[%0d]: got %0d want %0d", inst, xs[inst], e.x);
        end
        cyc();
        vsync = 1'b1;
        checks++;
        if (bs[inst] !== 1'b0) begin
            errors++;
            $display("FAIL frame_bounce_end[%0d]: got %b want 0", inst, bs[inst]);
        end
        repeat (3) cyc();
        checks++;
        if (int'(xs[inst]) != e.x || int'(ys[inst]) != e.y) begin
            errors++;
            $display("FAIL frame_held[%0d]: got (%0d,%0d) want (%0d,%0d)",
                     inst, xs[inst], ys[inst], e.x, e.y);
        end
        $display("frame inst=%0d speed=%0d -> x=%0d y=%0d bounce=%b%b",
                 inst, spd, xs[inst], ys[inst], e.bx, e.by);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        #3;
        checks++;
        if (xs[0] !== 11'd0 || ys[0] !== 10'd0 || ms !== 3'b000 || bs !== 3'b000
            || xs[1] !== 11'd1004 || ys[1] !== 10'd100) begin
            errors++;
            $display("FAIL reset_state: got x0=%0d y0=%0d x1=%0d y1=%0d m=%b b=%b want 0 0 1004 100 000 000",
                     xs[0], ys[0], xs[1], ys[1], ms, bs);
        end
        bad = 0;
        for (int f = 0; f < 6; f++) begin
            if (f == 3) reset = 1'b0;
            vsync = 1'b0;
            repeat (4) begin
                cyc();
                if (bs !== 3'b000 || ms !== 3'b000 || xs[0] !== 11'd0 || ys[0] !== 10'd0) bad++;
            end
            vsync = 1'b1;
            repeat (4) begin
                cyc();
                if (bs !== 3'b000 || ms !== 3'b000 || xs[0] !== 11'd0 || ys[0] !== 10'd0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_frames: got %0d bad cycles want 0", bad);
        end
        $display("reset/idle: 6 frames without launch, bad cycles=%0d", bad);
    endtask

    task automatic test_basic();
        do_reset();
        do_launch();
        do_frame(0, 3'd4, 4, 4, 1'b0, 1'b0, -1);
        do_frame(0, 3'd4, 8, 8, 1'b0, 1'b0, -1);
    endtask

    task automatic test_pause_speed();
        do_reset();
        do_launch();
        do_frame(0, 3'd3, 3, 3, 1'b0, 1'b0, -1);
        pause = 1'b1;
        speed = 3'd5;
        for (int f = 0; f < 2; f++) begin
            vsync = 1'b0;
            repeat (5) cyc();
            vsync = 1'b1;
            repeat (3) cyc();
        end
        checks++;
        if (xs[0] !== 11'd3 || ys[0] !== 10'd3 || ms[0] !== 1'b1) begin
            errors++;
            $display("FAIL pause_frozen: got (%0d,%0d,m=%b) want (3,3,m=1)", xs[0], ys[0], ms[0]);
        end
        $display("pause: 2 ticks ignored, x=%0d y=%0d", xs[0], ys[0]);
        pause = 1'b0;
        do_frame(0, 3'd0, 3, 3, 1'b0, 1'b0, -1);
        do_frame(0, 3'd2, 5, 5, 1'b0, 1'b0, 6);
        do_frame(0, 3'd6, 11, 11, 1'b0, 1'b0, -1);
    endtask

    task automatic test_right_edge();
        do_reset();
        do_launch();
        do_frame(1, 3'd7, 1008, 107, 1'b1, 1'b0, -1);
        do_frame(1, 3'd7, 1001, 114, 1'b0, 1'b0, -1);
    endtask

    task automatic test_exact_limit();
        do_reset();
        do_launch();
        do_frame(1, 3'd4, 1008, 104, 1'b0, 1'b0, -1);
        do_frame(1, 3'd4, 1008, 108, 1'b1, 1'b0, -1);
        do_frame(1, 3'd4, 1004, 112, 1'b0, 1'b0, -1);
    endtask

    task automatic test_corner();
        do_reset();
        do_launch();
        do_frame(2, 3'd3, 1008, 752, 1'b1, 1'b1, -1);
        do_frame(2, 3'd3, 1005, 749, 1'b0, 1'b0, -1);
    endtask

    task automatic test_stop();
        do_reset();
        do_launch();
        do_frame(1, 3'd7, 1008, 107, 1'b1, 1'b0, -1);
        vsync = 1'b0;
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (ms[1] !== 1'b0 || xs[1] !== 11'd1004 || ys[1] !== 10'd100 || bs[1] !== 1'b0) begin
            errors++;
            $display("FAIL stop_step_x: got (%0d,%0d,m=%b,b=%b) want (1004,100,m=0,b=0)",
                     xs[1], ys[1], ms[1], bs[1]);
        end
        vsync = 1'b1;
        repeat (3) cyc();
        checks++;
        if (ms[1] !== 1'b0 || xs[1] !== 11'd1004 || ys[1] !== 10'd100) begin
            errors++;
            $display("FAIL stop_parked: got (%0d,%0d,m=%b) want (1004,100,m=0)", xs[1], ys[1], ms[1]);
        end
        launch = 1'b1;
        stop = 1'b1;
        cyc();
        launch = 1'b0;
        stop = 1'b0;
        checks++;
        if (ms !== 3'b000) begin
            errors++;
            $display("FAIL stop_launch_idle: got %b want 000", ms);
        end
        $display("stop: mid-step stop parked x=%0d y=%0d", xs[1], ys[1]);
    endtask

    task automatic test_async_reset();
        do_reset();
        do_launch();
        speed = 3'd5;
        vsync = 1'b0;
        cyc();
        cyc();
        checks++;
        if (xs[0] !== 11'd5 || ys[0] !== 10'd0) begin
            errors++;
            $display("FAIL pre_reset_step: got (%0d,%0d) want (5,0)", xs[0], ys[0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (xs[0] !== 11'd0 || ys[0] !== 10'd0 || ms !== 3'b000 || bs !== 3'b000 || xs[1] !== 11'd1004) begin
            errors++;
            $display("FAIL async_reset: got x0=%0d y0=%0d m=%b b=%b x1=%0d want 0 0 000 000 1004",
                     xs[0], ys[0], ms, bs, xs[1]);
        end
        #1 reset = 1'b0;
        cyc();
        checks++;
        if (ys[0] !== 10'd0 || ms !== 3'b000 || bs !== 3'b000) begin
            errors++;
            $display("FAIL after_reset: got y0=%0d m=%b b=%b want 0 000 000", ys[0], ms, bs);
        end
        vsync = 1'b1;
        repeat (2) cyc();
        $display("async reset in STEP_Y: x=%0d y=%0d moving=%b", xs[0], ys[0], ms[0]);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause_speed();
        test_right_edge();
        test_exact_limit();
        test_corner();
        test_stop();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blob_mover.md
# blob_mover

Per-frame motion controller for one fixed-size sprite. Once per video frame, during vertical blanking, it steps the sprite's top-left corner by a programmable speed and reflects it off the screen edges. It sits between the video timing generator (vsync) and the sprite renderer; its `x`/`y` outputs feed the renderer's position inputs directly.

## Interface
- `WIDTH`, 16: sprite width in pixels.
- `HEIGHT`, 16: sprite height in pixels.
- `SCREEN_W`, 1024: visible width; x legal range 0..SCREEN_W-WIDTH.
- `SCREEN_H`, 768: visible height; y legal range 0..SCREEN_H-HEIGHT.
- `X_INIT`, 0: park x; must be ≤ SCREEN_W-WIDTH.
- `Y_INIT`, 0: park y; must be ≤ SCREEN_H-HEIGHT.

Ports:
- `clk`  in  1: pixel clock; the only clock.
- `reset`  in  1: asynchronous, active-high.
- `vsync`  in  1: active-low vertical sync, synchronous to `clk`.
- `launch`  in  1: one-cycle pulse; starts motion from IDLE.
- `stop`  in  1: one-cycle pulse; returns to IDLE and parks the sprite.
- `pause`  in  1: level; while high, frame ticks are ignored.
- `speed`  in  3: pixels per frame per axis (0..7), sampled at the frame tick.
- `x`  out  11: sprite left edge.
- `y`  out  10: sprite top edge.
- `moving`  out  1: high in every state except IDLE.
- `bounce`  out  1: one-cycle pulse per axis reflection.

## Operation
- Frame tick: `vsync_d` is `vsync` registered. Tick = `vsync_d & ~vsync` (falling edge), one cycle per frame.
- Direction flags `dx_neg` and `dy_neg`: 0 means increasing.
- FSM states: IDLE, WAIT_FRAME, STEP_X, STEP_Y.
  - IDLE: `x`=X_INIT, `y`=Y_INIT, dirs=0. `launch` goes to WAIT_FRAME.
  - WAIT_FRAME: tick & ~pause latches `speed` into `spd` and goes to STEP_X. Otherwise the state holds.
  - STEP_X: x update, then STEP_Y.
  - STEP_Y: y update, then WAIT_FRAME.
- Step arithmetic uses a 12-bit intermediate, with no wrap-around anywhere.
  - Positive direction: n = x + spd.
    - If n > SCREEN_W-WIDTH: x = SCREEN_W-WIDTH, `dx_neg`=1, bounce.
    - Else x = n.
  - Negative direction:
    - If x < spd: x = 0, `dx_neg`=0, bounce.
    - Else x = x − spd.
  - The y axis is identical, using SCREEN_H/HEIGHT and `dy_neg`.
  - Landing exactly on a limit is not a bounce; the reflection happens on the next step.
- `spd`=0: position is unchanged, no bounce, and the FSM still walks STEP_X and STEP_Y.
- `stop` has priority over everything in any state. Next state is IDLE, with position and dirs restored to init.
- Simultaneous events:
  - `stop`+`launch` in IDLE: stays in IDLE.
  - `stop` in the tick cycle: no step occurs.
- `launch` outside IDLE is ignored.
- `pause` only gates the tick. A step already in STEP_X or STEP_Y completes.
- Reset, including mid-step: all state is cleared immediately.

## Timing
- Reset values: `x`=X_INIT, `y`=Y_INIT, `moving`=0, `bounce`=0, state IDLE, `vsync_d`=1, dirs=0, `spd`=0.
- Tick detected in cycle T (the first cycle `vsync` samples 0 after 1):
  - State is STEP_X in T+1.
  - New `x` is visible in T+2, and new `y` in T+3.
  - State returns to WAIT_FRAME in T+3.
- `bounce` is registered and high in the same cycle the reflected coordinate first appears. A corner hit gives `bounce` high in T+2 and T+3.
- `launch` at T: `moving`=1 from T+1. The first step needs a tick at T+1 or later.
- `stop` at T: `moving`=0 and position parked from T+1.
- All updates fall within vsync low, so there is no mid-frame tearing.

## Test plan
- Reset and idle: assert `reset`, toggle `vsync` for 3 frames without `launch` -> `x`=0, `y`=0, `moving`=0, `bounce` never high.
- Basic step: `launch`, `speed`=4, one vsync falling edge -> `x`=4 two cycles after the tick, `y`=4 three cycles after, then held until the next tick.
- Right-edge reflection (X_INIT=1004, Y_INIT=100): `speed`=7, tick -> `x`=1008, `bounce` pulse, `y`=107. Next tick -> `x`=1001, `y`=114.
- Corner reflection (X_INIT=1008, Y_INIT=752): `launch`, `speed`=3, tick -> `x`=1008, `y`=752, `bounce` high 2 consecutive cycles. Next tick -> `x`=1005, `y`=749.
- Pause and speed: `pause`=1 over 2 ticks -> position frozen. `pause`=0 with `speed`=0 -> position unchanged. Change `speed` mid-frame -> the new value takes effect only at the next tick.
- Stop and reset mid-step: `stop` in STEP_X cycle -> next cycle IDLE, `x`=X_INIT, `y`=Y_INIT. Async `reset` pulse between clock edges during STEP_Y -> outputs go to reset values immediately.
